nibble_add_seq: RTL
===================

# nibble_add_seq

Multi-cycle wide adder that sequences one 4-bit ripple-carry slice across the nibbles of two WIDTH-bit operands, least-significant nibble first, carrying between nibbles in a register. Sits between a requester and a result consumer, with a valid/ready handshake on each side. Trades latency for area: one 4-bit adder serves any multiple-of-4 width.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 4. N = WIDTH/4 nibbles.
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start_valid  input  1  requester has operands
- start_ready  output  1  block can accept (high only in IDLE)
- a  input  WIDTH  operand A, sampled on start handshake
- b  input  WIDTH  operand B, sampled on start handshake
- cin  input  1  carry-in to nibble 0, sampled on start handshake
- sum  output  WIDTH  result, valid while done_valid
- cout  output  1  carry out of the top nibble
- ovf  output  1  signed overflow: carry into bit WIDTH-1 XOR cout
- done_valid  output  1  result available
- done_ready  input  1  consumer takes result
- busy  output  1  high in ADD or DONE

## Operation
- States: IDLE, ADD, DONE. Nibble counter idx, 0..N-1.
- IDLE: start_ready=1. On start_valid&&start_ready: latch a, b into shift registers, carry register <= cin, idx <= 0, sum/cout/ovf cleared, go ADD.
- ADD: slice adds low nibble of A/B shift registers plus carry register. At the edge: result nibble written to sum[4*idx+3:4*idx], carry register <= slice c3, operand registers shift right 4, idx++. When idx==N-1 at that edge: cout <= slice c3, ovf <= slice c2 XOR c3, go DONE.
- DONE: done_valid=1; sum/cout/ovf stable. On done_ready go IDLE. Output values hold until next start handshake.
- start_valid outside IDLE is ignored (start_ready=0); requester must hold it.
- Arithmetic is modulo 2^WIDTH; cout is the unsigned carry, ovf the two's-complement overflow.
- No bypass: a new start cannot be accepted in the same cycle as a done handshake.

## Timing
- Reset values: start_ready=1, done_valid=0, busy=0, sum=0, cout=0, ovf=0, state IDLE, idx=0, carry reg 0.
- Start handshake at edge T0; ADD occupies cycles T0+1..T0+N; done_valid first high in the cycle after edge T0+N, i.e. latency N+1 cycles from acceptance to done_valid.
- With done_ready tied high: DONE lasts exactly 1 cycle; start_ready returns the following cycle. Peak throughput one op per N+2 cycles.
- Backpressure: done_valid stays high and outputs frozen for any number of cycles with done_ready low.
- rst asserted at any point (including mid-ADD or in DONE) immediately forces all reset values; in-flight operation discarded, no done_valid produced.
- WIDTH=4 (N=1): single ADD cycle; DONE follows acceptance after 2 edges.

## Structure
- Shared package: state encoding (IDLE, ADD, DONE), NIBBLE_W=4 constant, helper for idx width ($clog2 of N, minimum 1).
- One sub-module, rca4_slice: purely combinational 4-bit ripple-carry adder from four full adders, outputs s[3:0] and per-bit carries c[3:0]; the controller uses c3 for the next carry and c2/c3 for ovf.
- Controller, counter, shift registers and result register in nibble_add_seq.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=1, done_ready=1 -> sum=0x5556, cout=0, ovf=0; done_valid exactly 5 cycles after acceptance, high for 1 cycle.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 nibbles); a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- a=0x8000, b=0x8000, cin=0, done_ready held low 3 cycles -> sum=0x0000, cout=1, ovf=1 held stable 4 cycles; IDLE one cycle after done_ready rises.
- start_valid held high with a second operand set during ADD -> start_ready=0, second op accepted only on return to IDLE, both results correct and in order.
- rst pulsed during second ADD cycle -> all outputs reset values immediately, no done_valid; a following op 0x0003+0x0004 -> 0x0007.
- WIDTH=4 instance: a=0xF, b=0x1, cin=1 -> sum=0x1, cout=1, ovf=0, done_valid 2 cycles after acceptance.

Source files
------------

// File: rtl/nibble_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nibble_add_seq_pkg
// Brief   : Shared state encoding, slice width and index sizing helper.
// Revision: 1.0
// ============================================================================
package nibble_add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nibble index width; a single-nibble adder still needs a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : nibble_add_seq_pkg
`default_nettype wire

// File: rtl/nibble_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : nibble_add_seq_if
// Brief   : Start/done handshake bundle between requester, adder and consumer.
// Revision: 1.0
// ============================================================================
interface nibble_add_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             done_valid;
    logic             done_ready;
    logic             busy;

    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, sum, cout, ovf, done_valid, busy
    );

    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, sum, cout, ovf, done_valid, busy
    );
endinterface : nibble_add_seq_if
`default_nettype wire

// File: rtl/nibble_add_seq_rca4_slice.sv
`default_nettype none
// ============================================================================
// Module  : rca4_slice
// Brief   : Combinational 4-bit ripple-carry adder exposing every bit carry.
// Revision: 1.0
// ============================================================================
module rca4_slice
    import nibble_add_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic [NIBBLE_W-1:0] c
);
    // c[i] is the carry out of bit i, so c[2] is the carry into the MSB.
    always_comb begin
        logic w_carry;
        s       = '0;
        c       = '0;
        w_carry = ci;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]    = a[i] ^ b[i] ^ w_carry;
            c[i]    = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
            w_carry = c[i];
        end
    end

endmodule : rca4_slice
`default_nettype wire

// File: rtl/nibble_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : nibble_add_seq
// Brief   : WIDTH-bit adder that steps one 4-bit slice across the operands,
//           least-significant nibble first, with valid/ready on both sides.
// Revision: 1.0
// ============================================================================
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    nibble_add_seq_if.slave  bus
);
    localparam int N  = WIDTH / NIBBLE_W;
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] c_last_idx = IW'(N - 1);

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_start_ready;
    logic             r_done_valid;
    logic             r_busy;

    logic [NIBBLE_W-1:0] w_s;
    logic [NIBBLE_W-1:0] w_c;
    logic                w_unused_carries;

    rca4_slice u_slice (
        .a  (r_a[NIBBLE_W-1:0]),
        .b  (r_b[NIBBLE_W-1:0]),
        .ci (r_carry),
        .s  (w_s),
        .c  (w_c)
    );

    assign w_unused_carries = &{1'b0, w_c[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_carry       <= 1'b0;
            r_sum         <= '0;
            r_cout        <= 1'b0;
            r_ovf         <= 1'b0;
            r_start_ready <= 1'b1;
            r_done_valid  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        r_a           <= bus.a;
                        r_b           <= bus.b;
                        r_carry       <= bus.cin;
                        r_idx         <= '0;
                        r_sum         <= '0;
                        r_cout        <= 1'b0;
                        r_ovf         <= 1'b0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_sum[NIBBLE_W*int'(r_idx) +: NIBBLE_W] <= w_s;
                    r_carry <= w_c[NIBBLE_W-1];
                    r_a     <= r_a >> NIBBLE_W;
                    r_b     <= r_b >> NIBBLE_W;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_last_idx) begin
                        // Overflow compares carry into the sign bit with carry out of it.
                        r_cout       <= w_c[NIBBLE_W-1];
                        r_ovf        <= w_c[NIBBLE_W-2] ^ w_c[NIBBLE_W-1];
                        r_idx        <= '0;
                        r_done_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_done_valid  <= 1'b0;
                    r_busy        <= 1'b0;
                    r_start_ready <= 1'b1;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = r_start_ready;
    assign bus.done_valid  = r_done_valid;
    assign bus.busy        = r_busy;
    assign bus.sum         = r_sum;
    assign bus.cout        = r_cout;
    assign bus.ovf         = r_ovf;

endmodule : nibble_add_seq
`default_nettype wire
